// File: rtl/chunked_adder.sv
// chunked_adder
//   Multi-cycle adder/subtractor that works through its operands CHUNK bits
//   per clock, least-significant chunk first. One operation takes
//   N = WIDTH/CHUNK clocks in RUN, followed by a single DONE cycle.
//
// Parameters
//   WIDTH     operand/result width (>= 1)
//   CHUNK     bits handled per clock; must divide WIDTH
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears every register)
//   start     request; sampled only in IDLE or DONE
//   sub       0: in_a + in_b, 1: in_a - in_b (sampled with start)
//   in_a/in_b operands (sampled with start)
//   busy      high while an operation is running
//   done      one-cycle pulse when result/carry/overflow update
//   result    sum/difference modulo 2^WIDTH, held between operations
//   carry     carry-out of MSB (for sub: 1 = no borrow)
//   overflow  two's-complement overflow of the operation
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             load_s;
  logic             last_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;   // already inverted for subtraction
  logic             c_r;
  logic [CNT_W-1:0] cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;  // effective (inverted-if-sub) MSB of B

  logic [CHUNK:0]   sum_s;
  logic [WIDTH-1:0] part_nx_s; // partial result including this cycle's chunk

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             overflow_r;

  // One chunk of ripple addition with the running carry.
  always_comb begin
    sum_s = {1'b0, a_sh_r[CHUNK-1:0]} + {1'b0, b_sh_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_r};
  end

  // The partial-result register only needs the N-1 earlier chunks; the
  // final chunk is merged straight into the result on the last RUN cycle.
  if (N > 1) begin : g_part
    logic [WIDTH-CHUNK-1:0] part_r;

    assign part_nx_s = {sum_s[CHUNK-1:0], part_r};

    // Partial-result shift register: new chunk enters at the top.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_r <= '0;
      end else if (state_r == ST_RUN) begin
        part_r <= part_nx_s[WIDTH-1:CHUNK];
      end else begin
        part_r <= part_r;
      end
    end
  end else begin : g_nopart
    assign part_nx_s = sum_s[CHUNK-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: start is honoured only in IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nx_s = ST_DONE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Operand shifters, carry and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else if (load_s) begin
      // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
      a_sh_r  <= in_a;
      b_sh_r  <= sub ? ~in_b : in_b;
      c_r     <= sub;
      cnt_r   <= '0;
      a_msb_r <= in_a[WIDTH-1];
      b_msb_r <= in_b[WIDTH-1] ^ sub;
    end else if (state_r == ST_RUN) begin
      a_sh_r  <= a_sh_r >> CHUNK;
      b_sh_r  <= b_sh_r >> CHUNK;
      c_r     <= sum_s[CHUNK];
      cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      a_sh_r  <= a_sh_r;
      b_sh_r  <= b_sh_r;
      c_r     <= c_r;
      cnt_r   <= cnt_r;
    end
  end

  // Registered outputs; result/carry/overflow change only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
      if (last_s) begin
        result_r   <= part_nx_s;
        carry_r    <= sum_s[CHUNK];
        overflow_r <= (a_msb_r == b_msb_r) && (part_nx_s[WIDTH-1] != a_msb_r);
      end else begin
        result_r   <= result_r;
        carry_r    <= carry_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign carry    = carry_r;
  assign overflow = overflow_r;

endmodule
